hazard_scoreboard: RTL and testbench

- Next-generation hazard unit for the in-order LoongArch pipeline, sitting between ID and the rest of the pipe.
- Replaces single-cycle load-use detection with a per-register latency scoreboard:
  - fixed-latency producers (load, multi-cycle mul) count down automatically;
  - variable-latency producers (divider) stay busy until an explicit release.
- Generates the ID stall and a parametrised per-stage flush vector; redirect has priority over stall.

---
 rtl/hazard_scoreboard_pkg.sv | 19 +
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_scoreboard_sb_cnt.sv | 34 +++
 rtl/hazard_scoreboard.sv | 97 +++++++++
 tb/tb_hazard_scoreboard.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: default geometry, hold code and stage indices.
package hazard_pkg;

   localparam int unsigned NREG_DEF   = 32;
   localparam int unsigned REG_AW_DEF = 5;
   localparam int unsigned LAT_W_DEF  = 3;
   localparam int unsigned NSTG_DEF   = 4;

   // All-ones latency marks a variable-latency producer that waits for a release
   localparam logic [LAT_W_DEF-1:0] LAT_HOLD = '1;

   localparam int unsigned STG_IF  = 0;
   localparam int unsigned STG_ID  = 1;
   localparam int unsigned STG_EX  = 2;
   localparam int unsigned STG_MEM = 3;

   localparam logic [NSTG_DEF-1:0] REDIR_MASK_DEF = 4'b1110;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request, release and hazard-result bundle between the pipeline and the scoreboard.
interface hazard_scoreboard_if #(
   parameter int unsigned NREG   = hazard_pkg::NREG_DEF,
   parameter int unsigned REG_AW = hazard_pkg::REG_AW_DEF,
   parameter int unsigned LAT_W  = hazard_pkg::LAT_W_DEF,
   parameter int unsigned NSTG   = hazard_pkg::NSTG_DEF
);

   logic              is_jump;
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic              id_wen;
   logic [REG_AW-1:0] id_rd;
   logic [LAT_W-1:0]  id_lat;
   logic              rel_valid;
   logic [REG_AW-1:0] rel_rd;
   logic              stall;
   logic [NSTG-1:0]   flush;
   logic [NREG-1:0]   busy_vec;
   logic [31:0]       perf_stall_cyc;
   logic [31:0]       perf_redir_cnt;

   modport master (
      output is_jump, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_wen, id_rd, id_lat, rel_valid, rel_rd,
      input  stall, flush, busy_vec, perf_stall_cyc, perf_redir_cnt
   );

   modport slave (
      input  is_jump, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_wen, id_rd, id_lat, rel_valid, rel_rd,
      output stall, flush, busy_vec, perf_stall_cyc, perf_redir_cnt
   );

endinterface

// File: rtl/hazard_scoreboard_sb_cnt.sv
// One scoreboard entry: load on issue, clear on release, park at the hold code, else count down.
module hazard_sb_cnt #(
   parameter int unsigned LAT_W = hazard_pkg::LAT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [LAT_W-1:0] i_lat,
   input  logic             i_rel,
   output logic             o_busy,
   output logic [LAT_W-1:0] o_cnt
);

   localparam logic [LAT_W-1:0] HOLD = '1;

   logic [LAT_W-1:0] r_cnt;

   // Issue beats release so a re-issued register is never cleared by a stale writeback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_lat;
      end else if (i_rel) begin
         r_cnt <= '0;
      end else if (r_cnt != HOLD && r_cnt != '0) begin
         r_cnt <= r_cnt - LAT_W'(1);
      end
   end

   assign o_busy = (r_cnt != '0);
   assign o_cnt  = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard producing the ID stall and per-stage flush vector.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned     NREG       = NREG_DEF,
   parameter int unsigned     REG_AW     = REG_AW_DEF,
   parameter int unsigned     LAT_W      = LAT_W_DEF,
   parameter int unsigned     NSTG       = NSTG_DEF,
   parameter logic [NSTG-1:0] REDIR_MASK = REDIR_MASK_DEF,
   parameter int unsigned     BUBBLE_IDX = STG_EX
) (
   input  logic                clk,
   input  logic                rst_n,
   hazard_scoreboard_if.slave  bus
);

   localparam logic [LAT_W-1:0] HOLD = '1;

   logic [LAT_W-1:0] w_cnt [NREG];
   logic [NREG-1:0]  w_busy;
   logic             w_raw1;
   logic             w_raw2;
   logic             w_waw;
   logic             w_haz;
   logic             w_stall;
   logic [NSTG-1:0]  w_flush;
   logic             w_issue;

   // Register 0 has no storage and never reports busy
   assign w_cnt[0]  = '0;
   assign w_busy[0] = 1'b0;

   for (genvar g = 1; g < NREG; g++) begin : g_ent
      hazard_sb_cnt #(
         .LAT_W (LAT_W)
      ) u_cnt (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_load (w_issue && (bus.id_rd == REG_AW'(g))),
         .i_lat  (bus.id_lat),
         .i_rel  (bus.rel_valid && (bus.rel_rd == REG_AW'(g))),
         .o_busy (w_busy[g]),
         .o_cnt  (w_cnt[g])
      );
   end

   // A younger writer may not land before an older one still in flight
   always_comb begin
      w_raw1 = bus.id_use_rs1 && (bus.id_rs1 != '0) && (w_cnt[bus.id_rs1] != '0);
      w_raw2 = bus.id_use_rs2 && (bus.id_rs2 != '0) && (w_cnt[bus.id_rs2] != '0);
      w_waw  = bus.id_wen && (bus.id_rd != '0) &&
               ((w_cnt[bus.id_rd] == HOLD) || (w_cnt[bus.id_rd] > bus.id_lat));
      w_haz  = bus.id_valid && (w_raw1 || w_raw2 || w_waw);
   end

   // Redirect outranks stall: the stalled instruction is being flushed anyway
   always_comb begin
      w_stall = 1'b0;
      w_flush = '0;
      if (bus.is_jump) begin
         w_flush = REDIR_MASK;
      end else if (w_haz) begin
         w_stall             = 1'b1;
         w_flush[BUBBLE_IDX] = 1'b1;
      end
   end

   assign w_issue = bus.id_valid && bus.id_wen && (bus.id_rd != '0) &&
                    !w_stall && !bus.is_jump;

   assign bus.stall    = w_stall;
   assign bus.flush    = w_flush;
   assign bus.busy_vec = w_busy;

`ifdef HAZARD_PERF_EN
   logic [31:0] r_perf_stall_cyc;
   logic [31:0] r_perf_redir_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_stall_cyc <= '0;
         r_perf_redir_cnt <= '0;
      end else begin
         if (w_stall)     r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
         if (bus.is_jump) r_perf_redir_cnt <= r_perf_redir_cnt + 32'd1;
      end
   end

   assign bus.perf_stall_cyc = r_perf_stall_cyc;
   assign bus.perf_redir_cnt = r_perf_redir_cnt;
`else
   assign bus.perf_stall_cyc = '0;
   assign bus.perf_redir_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

`ifdef HAZARD_PERF_EN
   localparam logic [31:0] EXP_PERF_STALL = 32'd3;
   localparam logic [31:0] EXP_PERF_REDIR = 32'd2;
`else
   localparam logic [31:0] EXP_PERF_STALL = 32'd0;
   localparam logic [31:0] EXP_PERF_REDIR = 32'd0;
`endif

   hazard_scoreboard_if bus ();

   hazard_scoreboard u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.is_jump    = 1'b0;
      bus.id_valid   = 1'b0;
      bus.id_rs1     = '0;
      bus.id_rs2     = '0;
      bus.id_use_rs1 = 1'b0;
      bus.id_use_rs2 = 1'b0;
      bus.id_wen     = 1'b0;
      bus.id_rd      = '0;
      bus.id_lat     = '0;
      bus.rel_valid  = 1'b0;
      bus.rel_rd     = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
      idle();
      bus.id_valid = 1'b1;
      bus.id_wen   = 1'b1;
      bus.id_rd    = rd;
      bus.id_lat   = lat;
   endtask

   task automatic use_rs1(input logic [4:0] rs);
      idle();
      bus.id_valid   = 1'b1;
      bus.id_use_rs1 = 1'b1;
      bus.id_rs1     = rs;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle();
      rst_n = 1'b0;
      #12;
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_flush", 32'(bus.flush), 32'd0);
      chk("rst_busy", bus.busy_vec, 32'd0);
      tick();
      rst_n = 1'b1;

      // load then use: lat=2 gives exactly two bubble cycles
      issue(5'd5, 3'd2);
      #1 chk("lu_issue_nostall", 32'(bus.stall), 32'd0);
      tick();
      chk("lu_busy5", 32'(bus.busy_vec[5]), 32'd1);
      use_rs1(5'd5);
      #1 chk("lu_stall_c1", 32'(bus.stall), 32'd1);
      chk("lu_flush_c1", 32'(bus.flush), 32'h4);
      tick();
      chk("lu_stall_c2", 32'(bus.stall), 32'd1);
      chk("lu_flush_c2", 32'(bus.flush), 32'h4);
      tick();
      chk("lu_stall_c3", 32'(bus.stall), 32'd0);
      chk("lu_flush_c3", 32'(bus.flush), 32'd0);
      chk("lu_busy5_clr", 32'(bus.busy_vec[5]), 32'd0);

      // divider hold until explicit release
      issue(5'd7, 3'd7);
      tick();
      idle();
      bus.id_valid   = 1'b1;
      bus.id_use_rs2 = 1'b1;
      bus.id_rs2     = 5'd7;
      for (int i = 0; i < 10; i++) begin
         if (i == 9) begin
            bus.rel_valid = 1'b1;
            bus.rel_rd    = 5'd7;
         end
         #1 chk($sformatf("div_stall_%0d", i), 32'(bus.stall), 32'd1);
         tick();
      end
      bus.rel_valid = 1'b0;
      #1 chk("div_after_rel", 32'(bus.stall), 32'd0);

      // redirect beats a RAW hazard and blocks the issue
      issue(5'd5, 3'd3);
      tick();
      idle();
      bus.id_valid   = 1'b1;
      bus.id_use_rs1 = 1'b1;
      bus.id_rs1     = 5'd5;
      bus.id_wen     = 1'b1;
      bus.id_rd      = 5'd9;
      bus.id_lat     = 3'd2;
      bus.is_jump    = 1'b1;
      #1 chk("redir_stall", 32'(bus.stall), 32'd0);
      chk("redir_flush", 32'(bus.flush), 32'hE);
      tick();
      idle();
      #1 chk("redir_no_write9", 32'(bus.busy_vec[9]), 32'd0);
      chk("redir_keep5", 32'(bus.busy_vec[5]), 32'd1);
      tick();
      tick();
      chk("redir_5_drained", 32'(bus.busy_vec[5]), 32'd0);

      // WAW behind a held divider result
      issue(5'd3, 3'd7);
      tick();
      issue(5'd3, 3'd1);
      #1 chk("waw_stall_a", 32'(bus.stall), 32'd1);
      tick();
      chk("waw_stall_b", 32'(bus.stall), 32'd1);
      bus.rel_valid = 1'b1;
      bus.rel_rd    = 5'd3;
      #1 chk("waw_stall_rel", 32'(bus.stall), 32'd1);
      tick();
      bus.rel_valid = 1'b0;
      #1 chk("waw_issue", 32'(bus.stall), 32'd0);
      tick();
      idle();
      #1 chk("waw_cnt3_one", 32'(bus.busy_vec[3]), 32'd1);
      tick();
      chk("waw_cnt3_zero", 32'(bus.busy_vec[3]), 32'd0);

      // issue and release of the same register in one cycle: issue wins
      issue(5'd4, 3'd3);
      bus.rel_valid = 1'b1;
      bus.rel_rd    = 5'd4;
      tick();
      idle();
      #1 chk("iss_beats_rel", 32'(bus.busy_vec[4]), 32'd1);
      tick();
      tick();
      // early completion of a fixed-latency entry
      issue(5'd8, 3'd6);
      tick();
      idle();
      bus.rel_valid = 1'b1;
      bus.rel_rd    = 5'd8;
      tick();
      idle();
      #1 chk("early_rel8", 32'(bus.busy_vec[8]), 32'd0);
      chk("busy_all_clear", bus.busy_vec, 32'd0);

      // register 0 never tracked
      issue(5'd0, 3'd3);
      tick();
      chk("r0_not_busy", bus.busy_vec, 32'd0);
      use_rs1(5'd0);
      #1 chk("r0_no_stall", 32'(bus.stall), 32'd0);
      tick();

      // async reset mid-countdown
      issue(5'd6, 3'd5);
      tick();
      idle();
      #1 chk("mr_busy6", 32'(bus.busy_vec[6]), 32'd1);
      tick();
      #2 rst_n = 1'b0;
      #1 chk("mr_busy_clear", bus.busy_vec, 32'd0);
      chk("mr_perf_stall0", bus.perf_stall_cyc, 32'd0);
      chk("mr_perf_redir0", bus.perf_redir_cnt, 32'd0);
      tick();
      rst_n = 1'b1;

      // perf: three stall cycles then two redirects
      issue(5'd5, 3'd3);
      tick();
      use_rs1(5'd5);
      tick();
      tick();
      tick();
      #1 chk("perf_stall_done", 32'(bus.stall), 32'd0);
      idle();
      bus.is_jump = 1'b1;
      tick();
      tick();
      idle();
      #1 chk("perf_stall_cyc", bus.perf_stall_cyc, EXP_PERF_STALL);
      chk("perf_redir_cnt", bus.perf_redir_cnt, EXP_PERF_REDIR);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
